// File: rtl/countdown_run_controller.sv
// countdown_run_controller: mm:ss down-counter with IDLE/READY/RUN/PAUSE/ALARM sequencing
// and a tick-timed alarm window; every output is registered.
module countdown_run_controller #(
  parameter int MIN_W      = 2,
  parameter int ALARM_SECS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic             start_stop,
  input  logic             clear,
  input  logic [MIN_W-1:0] minute_in,
  output logic [MIN_W-1:0] minute_count,
  output logic [5:0]       second_count,
  output logic             running,
  output logic             paused,
  output logic             alarm,
  output logic             done
);
  localparam int AW = $clog2(ALARM_SECS + 1);
  typedef enum logic [2:0] {IDLE, READY, RUN, PAUSE, ALARM} state_t;
  state_t           r_state, w_state;
  logic [MIN_W-1:0] r_min, w_min;
  logic [5:0]       r_sec, w_sec;
  logic [AW-1:0]    r_acnt, w_acnt;
  logic             r_running, r_paused, r_alarm, r_done, w_done;
  logic             w_preset_ok, w_zero, w_last_sec, w_alarm_end, w_can_load;
  assign w_preset_ok = minute_in != '0;
  assign w_zero      = r_min == '0 && r_sec == 6'd0;
  assign w_last_sec  = r_min == '0 && r_sec == 6'd1;
  assign w_alarm_end = r_acnt == AW'(ALARM_SECS - 1);
  assign w_can_load  = r_state == IDLE || r_state == READY || r_state == PAUSE;
  // Priority chain clear > load > start_stop > tick; a consumed higher input drops the rest.
  always_comb begin
    w_state = r_state;
    w_min   = r_min;
    w_sec   = r_sec;
    w_acnt  = r_acnt;
    w_done  = 1'b0;
    if (clear) begin
      w_state = IDLE;
      w_min   = '0;
      w_sec   = '0;
      w_acnt  = '0;
    end else if (load) begin
      if ((w_can_load || r_state == ALARM) && w_preset_ok) begin
        w_state = READY;
        w_min   = minute_in;
        w_sec   = '0;
        w_acnt  = '0;
      end else if (r_state == READY || r_state == PAUSE) begin
        w_state = IDLE;
        w_min   = '0;
        w_sec   = '0;
      end
    end else if (start_stop) begin
      w_state = r_state == READY ? RUN :
                r_state == RUN   ? PAUSE :
                r_state == PAUSE ? RUN :
                r_state == ALARM ? IDLE : r_state;
      w_acnt  = r_state == ALARM ? '0 : r_acnt;
    end else if (tick) begin
      if (r_state == RUN && !w_zero) begin
        w_sec   = r_sec == 6'd0 ? 6'd59 : r_sec - 6'd1;
        w_min   = r_sec == 6'd0 ? r_min - MIN_W'(1) : r_min;
        w_state = w_last_sec ? ALARM : RUN;
        w_done  = w_last_sec;
        w_acnt  = '0;
      end else if (r_state == ALARM) begin
        w_state = w_alarm_end ? IDLE : ALARM;
        w_acnt  = w_alarm_end ? '0 : r_acnt + AW'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_min     <= '0;
      r_sec     <= '0;
      r_acnt    <= '0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
      r_alarm   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_min     <= w_min;
      r_sec     <= w_sec;
      r_acnt    <= w_acnt;
      r_running <= w_state == RUN;
      r_paused  <= w_state == PAUSE;
      r_alarm   <= w_state == ALARM;
      r_done    <= w_done;
    end
  end
  assign minute_count = r_min;
  assign second_count = r_sec;
  assign running      = r_running;
  assign paused       = r_paused;
  assign alarm        = r_alarm;
  assign done         = r_done;
endmodule
